// File: rtl/os_inst_sequencer.sv
// os_inst_sequencer: hardware instruction sequencer for the output-stationary core.
// On start it fetches weights (to the IFIFO) and activations (to L0) for each
// input-channel pass. It then executes the pass and idles for a gap. After the
// last pass it drains the MAC array and copies the OFIFO results into pmem.
// inst is a registered 36-bit core instruction word.
// Optional feature: define SEQ_PERF_CNT_EN to build the perf_cycles run counter.
// When it is undefined, perf_cycles is tied to zero.
module os_inst_sequencer #(
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned LEN_X     = 9,
  parameter int unsigned LEN_W     = 9,
  parameter int unsigned NUM_IC    = 3,
  parameter int unsigned LEN_O     = 8,
  parameter int unsigned EXEC_CYC  = 9,
  parameter int unsigned GAP_CYC   = 16,
  parameter int unsigned DRAIN_CYC = 32,
  parameter int unsigned SRAM_LAT  = 1,
  parameter int unsigned X_BASE    = 0,
  parameter int unsigned W_BASE    = 1024,
  parameter int unsigned P_BASE    = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [35:0] inst,
  output logic        busy,
  output logic        done,
  output logic [31:0] perf_cycles
);

  // mode=1, all CEN/WEN high, everything else low
  localparam logic [35:0] IDLE_WORD = 36'h5800C0000;

  localparam int unsigned W_FETCH_CYC = LEN_W + SRAM_LAT;
  localparam int unsigned X_FETCH_CYC = LEN_X + SRAM_LAT;
  // L0/IFIFO are read only while the array still needs fresh operands
  localparam int unsigned RD_CYC      = EXEC_CYC - LEN_O + 1;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned CNT_MAX = max2(max2(max2(W_FETCH_CYC, X_FETCH_CYC),
                                              max2(EXEC_CYC, GAP_CYC)),
                                         max2(DRAIN_CYC, LEN_O));
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int unsigned IC_W    = $clog2(NUM_IC) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_FETCH,
    S_X_FETCH,
    S_EXEC,
    S_GAP,
    S_DRAIN,
    S_OFIFO_RD,
    S_DONE
  } state_t;

  // The bit map assumes an 11-bit address. ctl = {ofifo_rd, ififo_wr, ififo_rd, l0_rd, l0_wr, execute}.
  function automatic logic [35:0] make_inst(
    input logic              oe,
    input logic              cen_p,
    input logic              wen_p,
    input logic [ADDR_W-1:0] a_p,
    input logic              cen_x,
    input logic [ADDR_W-1:0] a_x,
    input logic [5:0]        ctl
  );
    return {oe, 1'b1, 1'b0, cen_p, wen_p, a_p, cen_x, 1'b1, a_x, ctl, 1'b0};
  endfunction

  state_t              state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [IC_W-1:0]     ic_r;
  logic [ADDR_W-1:0]   w_off_r;
  logic [ADDR_W-1:0]   x_off_r;
  logic [35:0]         inst_r;
  logic                busy_r;
  logic                done_r;

  logic                oe_s;
  logic                cen_p_s;
  logic                wen_p_s;
  logic [ADDR_W-1:0]   a_p_s;
  logic                cen_x_s;
  logic [ADDR_W-1:0]   a_x_s;
  logic [5:0]          ctl_s;
  logic [35:0]         word_s;

  // Decode the instruction word for the current state and phase count
  always_comb begin
    oe_s    = 1'b0;
    cen_p_s = 1'b1;
    wen_p_s = 1'b1;
    a_p_s   = '0;
    cen_x_s = 1'b1;
    a_x_s   = '0;
    ctl_s   = 6'b00_0000;
    case (state_r)
      S_W_FETCH: begin
        if (cnt_r < CNT_W'(LEN_W)) begin
          cen_x_s = 1'b0;
          a_x_s   = ADDR_W'(W_BASE) + w_off_r + ADDR_W'(cnt_r);
        end else begin
          cen_x_s = 1'b1;
          a_x_s   = '0;
        end
        // write strobe trails the address by the SRAM read latency
        ctl_s[4] = (cnt_r >= CNT_W'(SRAM_LAT));
      end
      S_X_FETCH: begin
        if (cnt_r < CNT_W'(LEN_X)) begin
          cen_x_s = 1'b0;
          a_x_s   = ADDR_W'(X_BASE) + x_off_r + ADDR_W'(cnt_r);
        end else begin
          cen_x_s = 1'b1;
          a_x_s   = '0;
        end
        ctl_s[1] = (cnt_r >= CNT_W'(SRAM_LAT));
      end
      S_EXEC: begin
        ctl_s[0] = 1'b1;
        ctl_s[3] = (cnt_r < CNT_W'(RD_CYC));
        ctl_s[2] = (cnt_r < CNT_W'(RD_CYC));
      end
      S_DRAIN: begin
        oe_s = 1'b1;
      end
      S_OFIFO_RD: begin
        if (ofifo_valid) begin
          ctl_s[5] = 1'b1;
          cen_p_s  = 1'b0;
          wen_p_s  = 1'b0;
          a_p_s    = ADDR_W'(P_BASE) + ADDR_W'(cnt_r);
        end else begin
          ctl_s[5] = 1'b0;
          cen_p_s  = 1'b1;
          wen_p_s  = 1'b1;
          a_p_s    = '0;
        end
      end
      S_IDLE, S_GAP, S_DONE: begin
        oe_s = 1'b0;
      end
      default: begin
        oe_s = 1'b0;
      end
    endcase
    word_s = make_inst(oe_s, cen_p_s, wen_p_s, a_p_s, cen_x_s, a_x_s, ctl_s);
  end

  // Sequencer FSM: phase counting, pass bookkeeping and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
      cnt_r   <= '0;
      ic_r    <= '0;
      w_off_r <= '0;
      x_off_r <= '0;
      inst_r  <= IDLE_WORD;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      inst_r <= word_s;
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            state_r <= S_W_FETCH;
            busy_r  <= 1'b1;
            cnt_r   <= '0;
            ic_r    <= '0;
            w_off_r <= '0;
            x_off_r <= '0;
          end
        end
        S_W_FETCH: begin
          if (cnt_r == CNT_W'(W_FETCH_CYC - 1)) begin
            cnt_r   <= '0;
            state_r <= S_X_FETCH;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        S_X_FETCH: begin
          if (cnt_r == CNT_W'(X_FETCH_CYC - 1)) begin
            cnt_r   <= '0;
            state_r <= S_EXEC;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        S_EXEC: begin
          if (cnt_r == CNT_W'(EXEC_CYC - 1)) begin
            cnt_r   <= '0;
            state_r <= S_GAP;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        S_GAP: begin
          if (cnt_r == CNT_W'(GAP_CYC - 1)) begin
            cnt_r <= '0;
            if (ic_r == IC_W'(NUM_IC - 1)) begin
              state_r <= S_DRAIN;
            end else begin
              ic_r    <= ic_r + IC_W'(1);
              w_off_r <= w_off_r + ADDR_W'(LEN_W);
              x_off_r <= x_off_r + ADDR_W'(LEN_X);
              state_r <= S_W_FETCH;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        S_DRAIN: begin
          if (cnt_r == CNT_W'(DRAIN_CYC - 1)) begin
            cnt_r   <= '0;
            state_r <= S_OFIFO_RD;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        S_OFIFO_RD: begin
          // stall indefinitely while the OFIFO is empty
          if (ofifo_valid) begin
            if (cnt_r == CNT_W'(LEN_O - 1)) begin
              cnt_r   <= '0;
              state_r <= S_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign inst = inst_r;
  assign busy = busy_r;
  assign done = done_r;

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] perf_r;

  // Run-length counter: cleared on an accepted start, counts every non-idle cycle, saturates
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_r <= 32'd0;
    end else if (state_r == S_IDLE) begin
      if (start) begin
        perf_r <= 32'd0;
      end
    end else if (perf_r != 32'hFFFF_FFFF) begin
      perf_r <= perf_r + 32'd1;
    end
  end

  assign perf_cycles = perf_r;
`else
  assign perf_cycles = 32'd0;
`endif

endmodule
